combo_lock_ctrl: RTL and testbench

//  Parametrised digit-sequence lock controller: one digit accepted per enter strobe, compared against
//  the stored code, 7-seg status shown on hex5..hex0. Adds retry counting, timed lockout, re-arm and

---
 rtl/combo_lock_pkg.sv | 76 +++++++
 rtl/combo_lock_ctrl_hex.sv | 62 ++++++
 rtl/combo_lock_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_combo_lock_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/combo_lock_pkg.sv
// combo_lock_pkg: shared types and 7-segment glyphs for the digit-sequence lock.
//   lock_state_e : controller FSM states
//   disp_mode_e  : what the HEX bank should show
//   hex_bus_t    : hex5..hex0 payload, active-low {g,f,e,d,c,b,a}
package combo_lock_pkg;

  localparam int unsigned SEG_W = 7;

  typedef enum logic [2:0] {
    ST_ENTRY   = 3'd0,
    ST_OPEN    = 3'd1,
    ST_CLOSED  = 3'd2,
    ST_LOCKOUT = 3'd3,
    ST_PROG    = 3'd4
  } lock_state_e;

  typedef enum logic [2:0] {
    DM_ENTRY  = 3'd0,
    DM_OPEN   = 3'd1,
    DM_CLOSED = 3'd2,
    DM_LOCK   = 3'd3,
    DM_PROG   = 3'd4
  } disp_mode_e;

  typedef struct packed {
    logic [SEG_W-1:0] h5;
    logic [SEG_W-1:0] h4;
    logic [SEG_W-1:0] h3;
    logic [SEG_W-1:0] h2;
    logic [SEG_W-1:0] h1;
    logic [SEG_W-1:0] h0;
  } hex_bus_t;

  // Active-low glyphs, bit order {g,f,e,d,c,b,a}
  localparam logic [SEG_W-1:0] SEG_OFF = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_0   = 7'h40;
  localparam logic [SEG_W-1:0] SEG_1   = 7'h79;
  localparam logic [SEG_W-1:0] SEG_2   = 7'h24;
  localparam logic [SEG_W-1:0] SEG_3   = 7'h30;
  localparam logic [SEG_W-1:0] SEG_4   = 7'h19;
  localparam logic [SEG_W-1:0] SEG_5   = 7'h12;
  localparam logic [SEG_W-1:0] SEG_6   = 7'h02;
  localparam logic [SEG_W-1:0] SEG_7   = 7'h78;
  localparam logic [SEG_W-1:0] SEG_8   = 7'h00;
  localparam logic [SEG_W-1:0] SEG_9   = 7'h10;
  localparam logic [SEG_W-1:0] SEG_O   = SEG_0;
  localparam logic [SEG_W-1:0] SEG_C   = 7'h46;
  localparam logic [SEG_W-1:0] SEG_E   = 7'h06;
  localparam logic [SEG_W-1:0] SEG_R   = 7'h2F;
  localparam logic [SEG_W-1:0] SEG_P   = 7'h0C;
  localparam logic [SEG_W-1:0] SEG_N   = 7'h2B;
  localparam logic [SEG_W-1:0] SEG_L   = 7'h47;
  localparam logic [SEG_W-1:0] SEG_S   = SEG_5;
  localparam logic [SEG_W-1:0] SEG_D   = 7'h21;

  // Decimal digit to glyph; anything above 9 is blank
  function automatic logic [SEG_W-1:0] seg_digit(input logic [3:0] d);
    logic [SEG_W-1:0] s;
    s = SEG_OFF;
    case (d)
      4'd0: s = SEG_0;
      4'd1: s = SEG_1;
      4'd2: s = SEG_2;
      4'd3: s = SEG_3;
      4'd4: s = SEG_4;
      4'd5: s = SEG_5;
      4'd6: s = SEG_6;
      4'd7: s = SEG_7;
      4'd8: s = SEG_8;
      4'd9: s = SEG_9;
      default: s = SEG_OFF;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/combo_lock_ctrl_hex.sv
// lock_hex_driver: combinational 7-segment decode for the lock status bank.
//   mode  in  display mode chosen from the registered FSM state
//   digit in  live switch digit (shown in ENTRY / PROG)
//   hex   out hex5..hex0, active-low segments
module lock_hex_driver
  import combo_lock_pkg::*;
#(
  parameter int unsigned DIGIT_W = 4
) (
  input  disp_mode_e           mode,
  input  logic [DIGIT_W-1:0]   digit,
  output hex_bus_t             hex
);

  logic             digit_ok_c;
  logic [SEG_W-1:0] digit_seg_c;

  always_comb begin
    digit_ok_c  = (32'(digit) <= 32'd9);
    digit_seg_c = digit_ok_c ? seg_digit(4'(digit)) : SEG_OFF;
    hex         = '{default: SEG_OFF};
    unique case (mode)
      DM_ENTRY: begin
        if (digit_ok_c) begin
          hex.h0 = digit_seg_c;
        end else begin
          // "ErrOr" on hex4..hex0
          hex.h4 = SEG_E;
          hex.h3 = SEG_R;
          hex.h2 = SEG_R;
          hex.h1 = SEG_O;
          hex.h0 = SEG_R;
        end
      end
      DM_OPEN: begin
        hex.h3 = SEG_O;
        hex.h2 = SEG_P;
        hex.h1 = SEG_E;
        hex.h0 = SEG_N;
      end
      DM_CLOSED: begin
        hex.h5 = SEG_C;
        hex.h4 = SEG_L;
        hex.h3 = SEG_O;
        hex.h2 = SEG_S;
        hex.h1 = SEG_E;
        hex.h0 = SEG_D;
      end
      DM_LOCK: begin
        hex.h5 = SEG_L;
        hex.h4 = SEG_O;
        hex.h3 = SEG_C;
      end
      DM_PROG: begin
        hex.h5 = SEG_P;
        hex.h0 = digit_seg_c;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/combo_lock_ctrl.sv
// combo_lock_ctrl: digit-sequence lock with retry counting, timed lockout,
// re-arm, and optional code reprogramming (macro LOCK_PROG_EN adds port prog
// and the PROG state).
//   clk, reset (async active-low), enter (digit strobe), digit_in
//   prog (LOCK_PROG_EN only), hex0..hex5 (active-low 7-seg)
//   unlocked, locked_out, tries_left (registered status)
module combo_lock_ctrl
  import combo_lock_pkg::*;
#(
  parameter int unsigned                 CODE_LEN    = 6,
  parameter int unsigned                 DIGIT_W     = 4,
  parameter logic [CODE_LEN*DIGIT_W-1:0] CODE        = 24'h722297,
  parameter int unsigned                 MAX_TRIES   = 3,
  parameter int unsigned                 LOCKOUT_CYC = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enter,
  input  logic [DIGIT_W-1:0]             digit_in,
`ifdef LOCK_PROG_EN
  input  logic                           prog,
`endif
  output logic [6:0]                     hex0,
  output logic [6:0]                     hex1,
  output logic [6:0]                     hex2,
  output logic [6:0]                     hex3,
  output logic [6:0]                     hex4,
  output logic [6:0]                     hex5,
  output logic                           unlocked,
  output logic                           locked_out,
  output logic [$clog2(MAX_TRIES+1)-1:0] tries_left
);

  localparam int unsigned CODE_W = CODE_LEN * DIGIT_W;
  localparam int unsigned POS_W  = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
  localparam int unsigned FC_W   = $clog2(MAX_TRIES + 1);
  localparam int unsigned LC_W   = (LOCKOUT_CYC > 1) ? $clog2(LOCKOUT_CYC) : 1;

  lock_state_e       state_q, state_d;
  logic [POS_W-1:0]  pos_q, pos_d;
  logic              mismatch_q, mismatch_d;
  logic [FC_W-1:0]   fail_q, fail_d;
  logic [LC_W-1:0]   lock_q, lock_d;
  logic              unlocked_q, unlocked_d;
  logic              locked_out_q, locked_out_d;
  logic [FC_W-1:0]   tries_q, tries_d;

  logic [CODE_W-1:0]  code_cur_c;
  logic [DIGIT_W-1:0] exp_digit_c;
  logic               digit_ok_c;
  logic               last_pos_c;
  logic               mismatch_n_c;
  disp_mode_e         mode_c;
  hex_bus_t           hex_c;

`ifdef LOCK_PROG_EN
  logic [CODE_W-1:0] code_q, code_d;
  logic [CODE_W-1:0] shadow_q, shadow_d;
  assign code_cur_c = code_q;
`else
  assign code_cur_c = CODE;
`endif

  // Expected digit for the current position; MS digit is entered first
  always_comb begin
    exp_digit_c  = DIGIT_W'(code_cur_c >> ((CODE_LEN - 1 - 32'(pos_q)) * DIGIT_W));
    digit_ok_c   = (32'(digit_in) <= 32'd9);
    last_pos_c   = (pos_q == POS_W'(CODE_LEN - 1));
    mismatch_n_c = mismatch_q | ~digit_ok_c | (digit_in != exp_digit_c);
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    pos_d      = pos_q;
    mismatch_d = mismatch_q;
    fail_d     = fail_q;
    lock_d     = lock_q;
`ifdef LOCK_PROG_EN
    code_d     = code_q;
    shadow_d   = shadow_q;
`endif
    unique case (state_q)
      ST_ENTRY: begin
        if (enter) begin
          if (last_pos_c) begin
            pos_d      = '0;
            mismatch_d = 1'b0;
            if (!mismatch_n_c) begin
              state_d = ST_OPEN;
              fail_d  = '0;
            end else if (32'(fail_q) + 32'd1 >= MAX_TRIES) begin
              state_d = ST_LOCKOUT;
              lock_d  = LC_W'(LOCKOUT_CYC - 1);
              fail_d  = FC_W'(MAX_TRIES);
            end else begin
              state_d = ST_CLOSED;
              fail_d  = fail_q + FC_W'(1);
            end
          end else begin
            pos_d      = pos_q + POS_W'(1);
            mismatch_d = mismatch_n_c;
          end
        end
      end
      ST_OPEN: begin
        if (enter) begin
`ifdef LOCK_PROG_EN
          if (prog) begin
            state_d = ST_PROG;
            pos_d   = '0;
          end else begin
            state_d = ST_ENTRY;
          end
`else
          state_d = ST_ENTRY;
`endif
        end
      end
      ST_CLOSED: begin
        if (enter) begin
          state_d = ST_ENTRY;
        end
      end
      ST_LOCKOUT: begin
        // enter is ignored for the whole lockout, exit cycle included
        if (lock_q == '0) begin
          state_d = ST_ENTRY;
          fail_d  = '0;
        end else begin
          lock_d = lock_q - LC_W'(1);
        end
      end
`ifdef LOCK_PROG_EN
      ST_PROG: begin
        if (enter) begin
          if (!digit_ok_c) begin
            state_d = ST_OPEN;
            pos_d   = '0;
          end else begin
            // Shift in so the first digit ends up most significant
            shadow_d = CODE_W'({shadow_q, digit_in});
            if (last_pos_c) begin
              code_d  = CODE_W'({shadow_q, digit_in});
              state_d = ST_ENTRY;
              pos_d   = '0;
            end else begin
              pos_d = pos_q + POS_W'(1);
            end
          end
        end
      end
`endif
      default: state_d = ST_ENTRY;
    endcase
    unlocked_d   = (state_d == ST_OPEN);
    locked_out_d = (state_d == ST_LOCKOUT);
    tries_d      = FC_W'(MAX_TRIES) - fail_d;
  end

  // State and status registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_ENTRY;
      pos_q        <= '0;
      mismatch_q   <= 1'b0;
      fail_q       <= '0;
      lock_q       <= '0;
      unlocked_q   <= 1'b0;
      locked_out_q <= 1'b0;
      tries_q      <= FC_W'(MAX_TRIES);
`ifdef LOCK_PROG_EN
      code_q       <= CODE;
      shadow_q     <= '0;
`endif
    end else begin
      state_q      <= state_d;
      pos_q        <= pos_d;
      mismatch_q   <= mismatch_d;
      fail_q       <= fail_d;
      lock_q       <= lock_d;
      unlocked_q   <= unlocked_d;
      locked_out_q <= locked_out_d;
      tries_q      <= tries_d;
`ifdef LOCK_PROG_EN
      code_q       <= code_d;
      shadow_q     <= shadow_d;
`endif
    end
  end

  // Display mode from registered state
  always_comb begin
    mode_c = DM_ENTRY;
    unique case (state_q)
      ST_ENTRY:   mode_c = DM_ENTRY;
      ST_OPEN:    mode_c = DM_OPEN;
      ST_CLOSED:  mode_c = DM_CLOSED;
      ST_LOCKOUT: mode_c = DM_LOCK;
      ST_PROG:    mode_c = DM_PROG;
      default:    mode_c = DM_ENTRY;
    endcase
  end

  lock_hex_driver #(
    .DIGIT_W (DIGIT_W)
  ) u_hex (
    .mode  (mode_c),
    .digit (digit_in),
    .hex   (hex_c)
  );

  assign hex0       = hex_c.h0;
  assign hex1       = hex_c.h1;
  assign hex2       = hex_c.h2;
  assign hex3       = hex_c.h3;
  assign hex4       = hex_c.h4;
  assign hex5       = hex_c.h5;
  assign unlocked   = unlocked_q;
  assign locked_out = locked_out_q;
  assign tries_left = tries_q;

endmodule

// File: tb/tb_combo_lock_ctrl.sv
// Bench for combo_lock_ctrl: directed stimulus pushes expected status into a
// queue, a negedge monitor pops and compares against the DUT outputs.
module tb_combo_lock_ctrl;

  logic       clk;
  logic       reset;
  logic       enter;
  logic [3:0] digit_in;
`ifdef LOCK_PROG_EN
  logic       prog;
`endif
  logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;
  logic       unlocked;
  logic       locked_out;
  logic [1:0] tries_left;

  combo_lock_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .enter      (enter),
    .digit_in   (digit_in),
`ifdef LOCK_PROG_EN
    .prog       (prog),
`endif
    .hex0       (hex0),
    .hex1       (hex1),
    .hex2       (hex2),
    .hex3       (hex3),
    .hex4       (hex4),
    .hex5       (hex5),
    .unlocked   (unlocked),
    .locked_out (locked_out),
    .tries_left (tries_left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [41:0] hx;
    logic        unl;
    logic        lo;
    logic [1:0]  tr;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   total = 0;
  int   bad   = 0;

  localparam logic [6:0]  OFF      = 7'h7F;
  localparam logic [41:0] V_ERR    = {OFF, 7'h06, 7'h2F, 7'h2F, 7'h40, 7'h2F};
  localparam logic [41:0] V_OPEN   = {OFF, OFF, 7'h40, 7'h0C, 7'h06, 7'h2B};
  localparam logic [41:0] V_CLOSED = {7'h46, 7'h47, 7'h40, 7'h12, 7'h06, 7'h21};
  localparam logic [41:0] V_LOC    = {7'h47, 7'h40, 7'h46, OFF, OFF, OFF};

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return OFF;
    endcase
  endfunction

  function automatic logic [41:0] v_entry(input logic [3:0] d);
    return {OFF, OFF, OFF, OFF, OFF, glyph(d)};
  endfunction

  function automatic logic [41:0] v_prog(input logic [3:0] d);
    return {7'h0C, OFF, OFF, OFF, OFF, glyph(d)};
  endfunction

  // Monitor: compare every queued expectation at the falling edge
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      total++;
      if ({hex5, hex4, hex3, hex2, hex1, hex0} !== cur.hx || unlocked !== cur.unl ||
          locked_out !== cur.lo || tries_left !== cur.tr) begin
        bad++;
        $display("FAIL %s: got hex=%h unl=%b lo=%b tries=%0d, want hex=%h unl=%b lo=%b tries=%0d",
                 cur.name, {hex5, hex4, hex3, hex2, hex1, hex0}, unlocked, locked_out,
                 tries_left, cur.hx, cur.unl, cur.lo, cur.tr);
      end
    end
  end

  task automatic expect_st(input string name, input logic [41:0] hx, input logic unl,
                           input logic lo, input logic [1:0] tr);
    exp_t e;
    e.name = name;
    e.hx   = hx;
    e.unl  = unl;
    e.lo   = lo;
    e.tr   = tr;
    exp_q.push_back(e);
    @(negedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] d);
    digit_in = d;
    enter    = 1'b1;
    @(posedge clk);
    #1;
    enter    = 1'b0;
  endtask

`ifdef LOCK_PROG_EN
  task automatic press_prog(input logic [3:0] d);
    prog = 1'b1;
    press(d);
    prog = 1'b0;
  endtask
`endif

  task automatic enter_code(input logic [23:0] c);
    for (int i = 5; i >= 0; i--) begin
      press(c[i*4 +: 4]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running, want finished");
    $fatal(1);
  end

  initial begin
    reset    = 1'b0;
    enter    = 1'b0;
    digit_in = 4'd0;
`ifdef LOCK_PROG_EN
    prog     = 1'b0;
`endif
    expect_st("reset", v_entry(4'd0), 1'b0, 1'b0, 2'd3);
    reset = 1'b1;

    // Correct code opens on the sixth strobe
    press(4'd7); press(4'd2); press(4'd2); press(4'd2); press(4'd9);
    expect_st("entry_5th", v_entry(4'd9), 1'b0, 1'b0, 2'd3);
    press(4'd7);
    expect_st("open", V_OPEN, 1'b1, 1'b0, 2'd3);
    press(4'd5);
    expect_st("rearm_open", v_entry(4'd5), 1'b0, 1'b0, 2'd3);

    // Invalid digit: live error, then counted as wrong
    digit_in = 4'hC;
    expect_st("live_err", V_ERR, 1'b0, 1'b0, 2'd3);
    press(4'hC); press(4'd2); press(4'd2); press(4'd2); press(4'd9); press(4'd7);
    expect_st("closed_inv", V_CLOSED, 1'b0, 1'b0, 2'd2);
    press(4'd0);
    expect_st("rearm_closed", v_entry(4'd0), 1'b0, 1'b0, 2'd2);
    enter_code(24'h111111);
    expect_st("closed_2", V_CLOSED, 1'b0, 1'b0, 2'd1);
    press(4'd0);
    enter_code(24'h111111);
    expect_st("lockout", V_LOC, 1'b0, 1'b1, 2'd0);

    // Hold enter through lockout: 15 more edges still locked, 16th exits
    digit_in = 4'd7;
    enter    = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
    end
    expect_st("lock_hold", V_LOC, 1'b0, 1'b1, 2'd0);
    @(posedge clk);
    #1;
    enter = 1'b0;
    expect_st("lock_exit", v_entry(4'd7), 1'b0, 1'b0, 2'd3);
    enter_code(24'h722297);
    expect_st("open_after_lock", V_OPEN, 1'b1, 1'b0, 2'd3);

    // Async reset mid-entry
    press(4'd0);
    press(4'd7); press(4'd2); press(4'd2);
    #2 reset = 1'b0;
    expect_st("reset_mid", v_entry(4'd2), 1'b0, 1'b0, 2'd3);
    reset = 1'b1;
    enter_code(24'h722297);
    expect_st("open_after_reset", V_OPEN, 1'b1, 1'b0, 2'd3);

    // Two failures then success restores tries
    press(4'd0);
    enter_code(24'h000000);
    expect_st("fail_a", V_CLOSED, 1'b0, 1'b0, 2'd2);
    press(4'd0);
    enter_code(24'h999999);
    expect_st("fail_b", V_CLOSED, 1'b0, 1'b0, 2'd1);
    press(4'd0);
    enter_code(24'h722297);
    expect_st("success", V_OPEN, 1'b1, 1'b0, 2'd3);

`ifdef LOCK_PROG_EN
    // Reprogram to 123456
    press_prog(4'd1);
    expect_st("prog_mode", v_prog(4'd1), 1'b0, 1'b0, 2'd3);
    enter_code(24'h123456);
    expect_st("prog_done", v_entry(4'd6), 1'b0, 1'b0, 2'd3);
    enter_code(24'h722297);
    expect_st("old_code", V_CLOSED, 1'b0, 1'b0, 2'd2);
    press(4'd0);
    enter_code(24'h123456);
    expect_st("new_code", V_OPEN, 1'b1, 1'b0, 2'd3);
    // Invalid digit aborts programming
    press_prog(4'd0);
    press(4'd1); press(4'd2); press(4'hA);
    expect_st("prog_abort", V_OPEN, 1'b1, 1'b0, 2'd3);
    press(4'd0);
    enter_code(24'h123456);
    expect_st("code_kept", V_OPEN, 1'b1, 1'b0, 2'd3);
`endif

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
